laser_point_feeder: RTL and testbench

- Upstream stage of the two-circle laser placement engine (LASER).
- Accepts host points over a valid/ready stream and buffers them into frames of NPTS points, using two ping-pong banks.
- Replays each frame onto the engine's free-running X/Y inputs with the exact per-cycle timing the engine samples.
- Drives the engine's reset to hold it whenever no complete frame is available.

---
 rtl/laser_pkg.sv | 20 ++
 rtl/laser_point_feeder_if.sv | 26 ++
 rtl/laser_pt_bank.sv | 28 ++
 rtl/laser_point_feeder.sv | 135 +++++++++++++
 tb/tb_laser_point_feeder.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// Shared defaults and state encoding for the laser point feeder slice.
// Imported by the feeder top and its point bank.
package laser_pkg;

  localparam int NPTS_DEF = 40;
  localparam int CW_DEF   = 4;
  localparam int FCW_DEF  = 8;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } feed_state_e;

  // Index width for an NPTS-deep bank; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/laser_point_feeder_if.sv
// Host point stream into the feeder: valid/ready handshake with one x/y point per beat.
// The host drives master, the feeder consumes through slave.
interface laser_point_feeder_if #(
  parameter int CW = laser_pkg::CW_DEF
) ();

  logic          IN_VALID;
  logic          IN_READY;
  logic [CW-1:0] IN_X;
  logic [CW-1:0] IN_Y;

  modport master (
    output IN_VALID,
    output IN_X,
    output IN_Y,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID,
    input  IN_X,
    input  IN_Y,
    output IN_READY
  );

endinterface

// File: rtl/laser_pt_bank.sv
// One frame of point storage: synchronous write port, combinational read mux.
// Contents are deliberately not reset; only the feeder's control state is.
module laser_pt_bank
  import laser_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  parameter int CW   = CW_DEF,
  parameter int AW   = idx_w(NPTS_DEF)
) (
  input  logic              CLK,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [2*CW-1:0]   wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [2*CW-1:0]   rdata_o
);

  logic [2*CW-1:0] mem_q [NPTS];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/laser_point_feeder.sv
// Buffers host points into ping-pong frames and replays each frame onto the
// LASER engine's X/Y inputs, holding the engine in reset while no frame is ready.
module laser_point_feeder
  import laser_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  parameter int CW   = CW_DEF,
  parameter int FCW  = FCW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  laser_point_feeder_if.slave  in_if,
  output logic [CW-1:0]        X,
  output logic [CW-1:0]        Y,
  output logic                 L_RST,
  input  logic                 DONE,
  output logic [FCW-1:0]       FRAME_CNT
);

  localparam int              AW   = idx_w(NPTS);
  localparam logic [AW-1:0]   LAST = AW'(NPTS - 1);

  feed_state_e     state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [AW-1:0]   ridx_q, ridx_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;

  logic            accept;
  logic [1:0]      bank_we;
  logic [2*CW-1:0] wdata;
  logic [2*CW-1:0] rdata0, rdata1, rdata;

  assign accept         = in_if.IN_VALID && !full_q[wb_q];
  assign in_if.IN_READY = !full_q[wb_q];
  assign wdata          = {in_if.IN_Y, in_if.IN_X};
  assign bank_we        = {accept && wb_q, accept && !wb_q};

  // Write side fills bank wb; read side drains bank rb. While streaming, rb is
  // full and wb is not, so a fill and a release in the same cycle never collide.
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    fcnt_d  = fcnt_q;

    if (accept) begin
      if (widx_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        widx_d       = '0;
      end else begin
        widx_d = widx_q + AW'(1);
      end
    end

    case (state_q)
      HOLD: begin
        if (full_q[rb_q]) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (ridx_q == LAST) begin
          full_d[rb_q] = 1'b0;
          rb_d         = ~rb_q;
          ridx_d       = '0;
          state_d      = WAIT_DONE;
        end else begin
          ridx_d = ridx_q + AW'(1);
        end
      end
      WAIT_DONE: begin
        // ridx is already 0 here, so the next frame's p0 sits on X/Y for the engine's DELAY sample.
        if (DONE) begin
          fcnt_d  = fcnt_q + FCW'(1);
          state_d = full_q[rb_q] ? STREAM : HOLD;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HOLD;
      full_q  <= '0;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      widx_q  <= '0;
      ridx_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      fcnt_q  <= fcnt_d;
    end
  end

  laser_pt_bank #(.NPTS(NPTS), .CW(CW), .AW(AW)) u_bank0 (
    .CLK     (CLK),
    .we_i    (bank_we[0]),
    .waddr_i (widx_q),
    .wdata_i (wdata),
    .raddr_i (ridx_q),
    .rdata_o (rdata0)
  );

  laser_pt_bank #(.NPTS(NPTS), .CW(CW), .AW(AW)) u_bank1 (
    .CLK     (CLK),
    .we_i    (bank_we[1]),
    .waddr_i (widx_q),
    .wdata_i (wdata),
    .raddr_i (ridx_q),
    .rdata_o (rdata1)
  );

  assign rdata     = rb_q ? rdata1 : rdata0;
  assign X         = rdata[CW-1:0];
  assign Y         = rdata[2*CW-1:CW];
  assign L_RST     = RST || (state_q == HOLD);
  assign FRAME_CNT = fcnt_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Bench for laser_point_feeder: directed frame sequences plus random traffic
// checked against a queue-based model of frames waiting for the engine.
module tb_laser_point_feeder;

  localparam int NP  = 40;
  localparam int CWB = 6;
  localparam int FW  = 8;
  localparam int PH_HOLD = 0, PH_STR = 1, PH_WAIT = 2;

  typedef logic [2*CWB-1:0] pt_t;

  typedef struct {
    logic           v;
    logic [CWB-1:0] x;
    logic [CWB-1:0] y;
    logic           e_rdy;
    logic           e_lrst;
    logic           e_xyv;
    logic [CWB-1:0] e_x;
    logic [CWB-1:0] e_y;
  } vec_t;

  logic           CLK;
  logic           RST;
  logic           DONE;
  logic           L_RST;
  logic [CWB-1:0] X;
  logic [CWB-1:0] Y;
  logic [FW-1:0]  FRAME_CNT;

  laser_point_feeder_if #(.CW(CWB)) hif ();

  laser_point_feeder #(.NPTS(NP), .CW(CWB), .FCW(FW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_if     (hif),
    .X         (X),
    .Y         (Y),
    .L_RST     (L_RST),
    .DONE      (DONE),
    .FRAME_CNT (FRAME_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   total;
  int   bad;
  int   cyc;
  vec_t tv [82];

  // Model: complete frames queued back-to-back, the frame being assembled, and
  // where the engine-facing side is (holding, streaming point pos, awaiting DONE).
  pt_t  full_pts [$];
  pt_t  part [$];
  pt_t  sent [$];
  int   ph;
  int   pos;
  int   fcnt;
  bit   mdl_on;

  function automatic int nfr();
    return full_pts.size() / NP;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input pt_t p, input logic dn);
    int nf;
    bit acc;
    if (rst) begin
      full_pts.delete();
      part.delete();
      ph     = PH_HOLD;
      pos    = 0;
      fcnt   = 0;
      mdl_on = 1'b1;
      return;
    end
    if (!mdl_on) return;
    nf  = nfr();
    acc = v && (nf < 2);
    if (ph == PH_HOLD) begin
      if (nf > 0) begin
        ph  = PH_STR;
        pos = 0;
      end
    end else if (ph == PH_STR) begin
      if (pos == NP - 1) begin
        repeat (NP) void'(full_pts.pop_front());
        ph  = PH_WAIT;
        pos = 0;
      end else begin
        pos++;
      end
    end else if (dn) begin
      fcnt = (fcnt + 1) % (1 << FW);
      ph   = (nf > 0) ? PH_STR : PH_HOLD;
      pos  = 0;
    end
    if (acc) begin
      part.push_back(p);
      if (part.size() == NP) begin
        foreach (part[i]) full_pts.push_back(part[i]);
        part.delete();
      end
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    if (mdl_on) begin
      chk("m_ready", 32'(hif.IN_READY), 32'(nfr() < 2));
      chk("m_lrst", 32'(L_RST), 32'(RST || (ph == PH_HOLD)));
      chk("m_fcnt", 32'(FRAME_CNT), 32'(fcnt));
      if (ph == PH_STR) begin
        chk("m_xy_stream", 32'({Y, X}), 32'(full_pts[pos]));
      end else if (ph == PH_WAIT && nfr() > 0) begin
        chk("m_xy_wait", 32'({Y, X}), 32'(full_pts[0]));
      end
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    model_step(RST, hif.IN_VALID, {hif.IN_Y, hif.IN_X}, DONE);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      settle();
      advance();
    end
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    DONE         = 1'b0;
    hif.IN_VALID = 1'b0;
    idle(2);
    RST = 1'b0;
  endtask

  // Offer n random points back-to-back; bounded so a stuck IN_READY still ends.
  task automatic push(input int n, input string nm);
    int  acc;
    int  k;
    bit  a;
    acc = 0;
    k   = 0;
    while (acc < n && k < n + 200) begin
      hif.IN_VALID = 1'b1;
      hif.IN_X     = CWB'($urandom);
      hif.IN_Y     = CWB'($urandom);
      settle();
      a = hif.IN_READY;
      advance();
      if (a) begin
        sent.push_back({hif.IN_Y, hif.IN_X});
        acc++;
      end
      k++;
    end
    hif.IN_VALID = 1'b0;
    if (acc != n) chk(nm, 32'(acc), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  acc;
    int  c81;
    bit  r80;
    bit  a;
    int  b;

    total = 0; bad = 0; cyc = 0;
    mdl_on = 1'b0; ph = PH_HOLD; pos = 0; fcnt = 0;
    RST = 1'b1; DONE = 1'b0;
    hif.IN_VALID = 1'b0; hif.IN_X = '0; hif.IN_Y = '0;

    // Test 1: one frame of (i, 39-i), then its replay.
    for (int i = 0; i < 82; i++) begin
      tv[i].v = 1'b0; tv[i].x = '0; tv[i].y = '0;
      tv[i].e_rdy = 1'b1; tv[i].e_lrst = 1'b0; tv[i].e_xyv = 1'b0;
      tv[i].e_x = '0; tv[i].e_y = '0;
      if (i < NP) begin
        tv[i].v = 1'b1; tv[i].x = CWB'(i); tv[i].y = CWB'(39 - i);
        tv[i].e_lrst = 1'b1;
      end else if (i == NP) begin
        tv[i].e_lrst = 1'b1;
      end else if (i <= 2 * NP) begin
        tv[i].e_xyv = 1'b1;
        tv[i].e_x = CWB'(i - 41); tv[i].e_y = CWB'(39 - (i - 41));
      end
    end

    do_reset();
    for (int i = 0; i < 82; i++) begin
      hif.IN_VALID = tv[i].v;
      hif.IN_X     = tv[i].x;
      hif.IN_Y     = tv[i].y;
      settle();
      if (i == 0) chk("t1_reset_fcnt", 32'(FRAME_CNT), 32'd0);
      chk("t1_ready", 32'(hif.IN_READY), 32'(tv[i].e_rdy));
      chk("t1_lrst", 32'(L_RST), 32'(tv[i].e_lrst));
      if (tv[i].e_xyv) begin
        chk("t1_x", 32'(X), 32'(tv[i].e_x));
        chk("t1_y", 32'(Y), 32'(tv[i].e_y));
      end
      advance();
    end
    hif.IN_VALID = 1'b0;

    // Test 2: 81 points offered continuously with no DONE.
    do_reset();
    sent.delete();
    acc = 0; n = 0; c81 = -1; r80 = 1'b1;
    while (acc < 81 && n < 200) begin
      hif.IN_VALID = 1'b1;
      hif.IN_X     = CWB'($urandom);
      hif.IN_Y     = CWB'($urandom);
      settle();
      a = hif.IN_READY;
      if (n == 80) r80 = a;
      advance();
      if (a) begin
        sent.push_back({hif.IN_Y, hif.IN_X});
        acc++;
        if (acc == 81) c81 = n;
      end
      n++;
    end
    hif.IN_VALID = 1'b0;
    chk("t2_accepts", 32'(acc), 32'd81);
    chk("t2_ready_after_80", 32'(r80), 32'd0);
    chk("t2_accept81_cycle", 32'(c81), 32'd81);

    // Test 3: frame 1 already full when DONE arrives.
    DONE = 1'b1;
    settle();
    chk("t3_done_xy", 32'({Y, X}), 32'(sent[40]));
    chk("t3_done_lrst", 32'(L_RST), 32'd0);
    advance();
    DONE = 1'b0;
    settle();
    chk("t3_d1_xy", 32'({Y, X}), 32'(sent[40]));
    chk("t3_d1_lrst", 32'(L_RST), 32'd0);
    chk("t3_fcnt", 32'(FRAME_CNT), 32'd1);
    advance();
    settle();
    chk("t3_d2_xy", 32'({Y, X}), 32'(sent[41]));
    advance();
    idle(38);

    // Test 4: DONE with only a partial frame buffered.
    DONE = 1'b1;
    settle();
    advance();
    DONE = 1'b0;
    settle();
    chk("t4_lrst_d1", 32'(L_RST), 32'd1);
    chk("t4_fcnt", 32'(FRAME_CNT), 32'd2);
    advance();
    idle(8);
    push(39, "t4_push");
    settle();
    chk("t4_hold", 32'(L_RST), 32'd1);
    advance();
    settle();
    chk("t4_lrst_drop", 32'(L_RST), 32'd0);
    chk("t4_p0", 32'({Y, X}), 32'(sent[80]));
    advance();
    idle(39);

    // Test 5: both banks full, then DONE and blocked writes mid-stream.
    push(80, "t5_push");
    settle();
    chk("t5_blocked", 32'(hif.IN_READY), 32'd0);
    advance();
    DONE = 1'b1;
    settle();
    advance();
    DONE = 1'b0;
    idle(20);
    DONE         = 1'b1;
    hif.IN_VALID = 1'b1;
    hif.IN_X     = CWB'($urandom);
    hif.IN_Y     = CWB'($urandom);
    settle();
    chk("t5_ready_low", 32'(hif.IN_READY), 32'd0);
    advance();
    DONE = 1'b0;
    repeat (4) begin
      settle();
      chk("t5_ready_low", 32'(hif.IN_READY), 32'd0);
      advance();
    end
    hif.IN_VALID = 1'b0;
    settle();
    chk("t5_fcnt_hold", 32'(FRAME_CNT), 32'd3);
    advance();
    idle(13);
    settle();
    chk("t5_ready_last_pt", 32'(hif.IN_READY), 32'd0);
    advance();
    settle();
    chk("t5_ready_rise", 32'(hif.IN_READY), 32'd1);
    advance();

    // Test 6: reset at stream point 20, then a fresh frame.
    DONE = 1'b1;
    settle();
    advance();
    DONE = 1'b0;
    idle(20);
    RST = 1'b1;
    settle();
    chk("t6_lrst_in_rst", 32'(L_RST), 32'd1);
    advance();
    RST = 1'b0;
    settle();
    chk("t6_fcnt", 32'(FRAME_CNT), 32'd0);
    chk("t6_ready", 32'(hif.IN_READY), 32'd1);
    chk("t6_lrst", 32'(L_RST), 32'd1);
    advance();
    b = sent.size();
    push(40, "t6_push");
    settle();
    advance();
    for (int k = 0; k < NP; k++) begin
      settle();
      chk("t6_pt", 32'({Y, X}), 32'(sent[b + k]));
      chk("t6_lrst_stream", 32'(L_RST), 32'd0);
      advance();
    end

    // Random traffic: bursty host, sporadic DONE, rare resets.
    for (int k = 0; k < 4000; k++) begin
      hif.IN_VALID = ($urandom_range(0, 3) != 0);
      hif.IN_X     = CWB'($urandom);
      hif.IN_Y     = CWB'($urandom);
      DONE         = ($urandom_range(0, 9) == 0);
      RST          = ($urandom_range(0, 999) == 0);
      settle();
      advance();
    end
    RST = 1'b0; DONE = 1'b0; hif.IN_VALID = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
